// File: rtl/efi_output_bank.sv
// Angle-scheduled N-channel output driver bank: start/end windows in (tooth, count)
// space, shadow config committed at tooth 0, per-channel dwell guard, distributor folding.
module efi_output_bank #(
  parameter int N_CH      = 4,
  parameter int TOOTH_W   = 8,
  parameter int COUNT_W   = 24,
  parameter int DWELL_W   = 24,
  parameter int MAX_DWELL = 40000,
  localparam int CFG_W    = 2*TOOTH_W + 2*COUNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  synced,
  input  logic                  trigger,
  input  logic [TOOTH_W-1:0]    eng_phase,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  distributor_mode,
  input  logic [N_CH*CFG_W-1:0] cfg_in,
  input  logic                  cfg_load,
  input  logic                  fault_clr,
  output logic                  cfg_pending,
  output logic [N_CH-1:0]       ch_out,
  output logic [N_CH-1:0]       dwell_fault
);

  typedef enum logic {CH_OFF = 1'b0, CH_ON = 1'b1} ch_state_e;

  // Holds at all-ones so a missing-tooth gap can never wrap back onto a match.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [N_CH*CFG_W-1:0] shadow_q;
  logic [N_CH*CFG_W-1:0] active_q;
  logic [TOOTH_W-1:0]    tooth_r;
  logic [COUNT_W-1:0]    tcnt;
  logic                  commit;
  logic [N_CH-1:0]       on_q;
  logic [N_CH-1:0]       fault_set;

  assign commit = (trigger && (eng_phase == '0)) || (cfg_pending && !synced);

  // Position tracking and configuration double buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tooth_r     <= '0;
      tcnt        <= '1;
      shadow_q    <= '0;
      active_q    <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (trigger) begin
        tooth_r <= eng_phase;
        tcnt    <= '0;
      end else begin
        tcnt    <= sat_inc(tcnt);
      end
      if (commit)   active_q <= shadow_q;
      if (cfg_load) shadow_q <= cfg_in;
      cfg_pending <= cfg_load | (cfg_pending & ~commit);
    end
  end

  // Per-channel window state and dwell guard
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [TOOTH_W-1:0] st_tooth, en_tooth;
    logic [COUNT_W-1:0] st_count, en_count;
    logic               start_hit, end_hit, gate, expire;
    logic [DWELL_W-1:0] dwell_q;
    ch_state_e          state_q, state_d;

    assign {st_tooth, en_tooth, st_count, en_count} = active_q[c*CFG_W +: CFG_W];
    assign start_hit = (tooth_r == st_tooth) && (tcnt == st_count);
    assign end_hit   = (tooth_r == en_tooth) && (tcnt == en_count);
    assign gate      = synced & ch_en[c];
    assign expire    = (state_q == CH_ON) && (dwell_q == DWELL_W'(MAX_DWELL));

    always_comb begin
      state_d = state_q;
      case (state_q)
        CH_OFF: if (start_hit && !end_hit && gate) state_d = CH_ON;
        CH_ON:  if (end_hit || expire || !gate)    state_d = CH_OFF;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= CH_OFF;
        dwell_q <= '0;
      end else begin
        state_q <= state_d;
        dwell_q <= (state_q == CH_ON && state_d == CH_ON) ? dwell_q + 1'b1 : '0;
      end
    end

    assign on_q[c]      = (state_q == CH_ON);
    assign fault_set[c] = expire;
  end

  // A fault raised in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dwell_fault <= '0;
    else       dwell_fault <= (dwell_fault & ~{N_CH{fault_clr}}) | fault_set;
  end

  always_comb begin
    ch_out = '0;
    if (distributor_mode) ch_out[0] = |on_q;
    else                  ch_out    = on_q;
  end

endmodule

// File: tb/tb_efi_output_bank.sv
// Bench for efi_output_bank: two instances (default and short dwell limit) checked every
// cycle against a tooth/count reference model, plus directed window/latency checks.
module tb_efi_output_bank;
  localparam int N     = 4;
  localparam int TW    = 8;
  localparam int CW    = 24;
  localparam int CFGW  = 2*TW + 2*CW;
  localparam int MAXD0 = 40000;
  localparam int MAXD1 = 50;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, synced, trigger, distributor_mode, cfg_load, fault_clr;
  logic [TW-1:0]     eng_phase;
  logic [N-1:0]      ch_en;
  logic [N*CFGW-1:0] cfg_in;
  logic              cfg_pending0, cfg_pending1;
  logic [N-1:0]      ch_out0, ch_out1, fault0, fault1;

  always #5 clk = ~clk;

  efi_output_bank dut (
    .clk(clk), .reset(reset), .synced(synced), .trigger(trigger), .eng_phase(eng_phase),
    .ch_en(ch_en), .distributor_mode(distributor_mode), .cfg_in(cfg_in), .cfg_load(cfg_load),
    .fault_clr(fault_clr), .cfg_pending(cfg_pending0), .ch_out(ch_out0), .dwell_fault(fault0));

  efi_output_bank #(.MAX_DWELL(MAXD1)) dut_d (
    .clk(clk), .reset(reset), .synced(synced), .trigger(trigger), .eng_phase(eng_phase),
    .ch_en(ch_en), .distributor_mode(distributor_mode), .cfg_in(cfg_in), .cfg_load(cfg_load),
    .fault_clr(fault_clr), .cfg_pending(cfg_pending1), .ch_out(ch_out1), .dwell_fault(fault1));

  typedef struct {int st; int et; int sc; int ec;} win_t;
  win_t req[N], m_sh[N], m_act[N];
  int   m_tooth, m_cnt;
  bit   m_pending;
  bit   m_on    [2][N];
  int   m_run   [2][N];
  bit   m_fault [2][N];

  int checks = 0, errors = 0, cyc = 0;
  int t_trig [60];
  int hi_cnt [2], first_hi [2], last_hi [2], others_hi;
  int g_load_tooth = -1, g_load_at = -1, g_clr_tooth = -1, g_clr_at = -1;
  bit g_rand = 1'b0;
  int g_len = 100;

  function automatic int maxd(input int i);
    return (i == 0) ? MAXD0 : MAXD1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_win(input int c, input int st, input int et, input int sc, input int ec);
    req[c] = '{st, et, sc, ec};
    cfg_in[c*CFGW +: CFGW] = {TW'(st), TW'(et), CW'(sc), CW'(ec)};
  endtask

  task automatic randomize_req(input int len);
    for (int c = 0; c < N; c++)
      set_win(c, $urandom_range(0, 59), $urandom_range(0, 59),
              $urandom_range(0, len - 1), $urandom_range(0, len - 1));
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_sh[c]  = '{0, 0, 0, 0};
      m_act[c] = '{0, 0, 0, 0};
      for (int i = 0; i < 2; i++) begin
        m_on[i][c] = 1'b0; m_run[i][c] = 0; m_fault[i][c] = 1'b0;
      end
    end
    m_tooth = 0; m_cnt = CNT_MAX; m_pending = 1'b0;
  endtask

  // Advance the reference by one clock using the inputs present at that edge.
  task automatic model_update();
    bit commit, sh, eh, gate, ex, nxt;
    commit = (trigger && eng_phase == 0) || (m_pending && !synced);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < N; c++) begin
        sh   = (m_tooth == m_act[c].st) && (m_cnt == m_act[c].sc);
        eh   = (m_tooth == m_act[c].et) && (m_cnt == m_act[c].ec);
        gate = synced && ch_en[c];
        if (m_on[i][c]) begin
          ex  = (m_run[i][c] == maxd(i));
          nxt = !(eh || ex || !gate);
        end else begin
          ex  = 1'b0;
          nxt = sh && !eh && gate;
        end
        m_fault[i][c] = (m_fault[i][c] && !fault_clr) || ex;
        m_run[i][c]   = (m_on[i][c] && nxt) ? m_run[i][c] + 1 : 0;
        m_on[i][c]    = nxt;
      end
    if (commit) for (int c = 0; c < N; c++) m_act[c] = m_sh[c];
    if (cfg_load) for (int c = 0; c < N; c++) m_sh[c] = req[c];
    m_pending = cfg_load || (m_pending && !commit);
    if (trigger) begin
      m_tooth = int'(eng_phase); m_cnt = 0;
    end else if (m_cnt < CNT_MAX) begin
      m_cnt++;
    end
  endtask

  function automatic logic [N-1:0] exp_out(input int i);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_on[i][c];
    if (distributor_mode) return {{(N-1){1'b0}}, |v};
    return v;
  endfunction

  function automatic logic [N-1:0] exp_fault(input int i);
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_fault[i][c];
    return v;
  endfunction

  task automatic compare_all();
    chk("ch_out", ch_out0, exp_out(0));
    chk("dwell_fault", fault0, exp_fault(0));
    chk("cfg_pending", cfg_pending0, m_pending);
    chk("ch_out_d", ch_out1, exp_out(1));
    chk("dwell_fault_d", fault1, exp_fault(1));
    chk("cfg_pending_d", cfg_pending1, m_pending);
  endtask

  task automatic clear_trk();
    for (int i = 0; i < 2; i++) begin
      hi_cnt[i] = 0; first_hi[i] = -1; last_hi[i] = -1;
    end
    others_hi = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_update();
    cyc++;
    #1;
    compare_all();
    if (ch_out0[0]) begin hi_cnt[0]++; if (first_hi[0] < 0) first_hi[0] = cyc; last_hi[0] = cyc; end
    if (ch_out1[0]) begin hi_cnt[1]++; if (first_hi[1] < 0) first_hi[1] = cyc; last_hi[1] = cyc; end
    if (ch_out0[N-1:1] != '0 || ch_out1[N-1:1] != '0) others_hi++;
  endtask

  task automatic load_cfg();
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic options(input int p, input int j);
    cfg_load  = (p == g_load_tooth && j == g_load_at);
    fault_clr = (p == g_clr_tooth && j == g_clr_at);
    if (g_rand) begin
      if ($urandom_range(0, 99) == 0) fault_clr = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        randomize_req(g_len);
        cfg_load = 1'b1;
      end
      synced = ($urandom_range(0, 299) != 0);
    end
  endtask

  task automatic run_teeth(input int first, input int last, input int len);
    for (int p = first; p <= last; p++) begin
      options(p, 0);
      eng_phase = TW'(p);
      trigger   = 1'b1;
      t_trig[p] = cyc;
      step();
      trigger = 1'b0;
      for (int j = 1; j < len; j++) begin
        options(p, j);
        step();
      end
    end
    cfg_load = 1'b0; fault_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; synced = 1'b0; trigger = 1'b0; eng_phase = '0; ch_en = '0;
    distributor_mode = 1'b0; cfg_load = 1'b0; fault_clr = 1'b0; cfg_in = '0;
    for (int c = 0; c < N; c++) set_win(c, 0, 0, 0, 0);
    model_reset();
    clear_trk();
    #1;
    compare_all();
    step(); step();
    reset = 1'b0;
    step();

    // Window inside one tooth
    set_win(0, 5, 5, 10, 110);
    ch_en = 4'b0001; synced = 1'b1;
    load_cfg();
    chk("pending_after_load", cfg_pending0, 1);
    clear_trk();
    run_teeth(0, 5, 200);
    run_teeth(6, 59, 100);
    chk("t1_first", first_hi[0], t_trig[5] + 12);
    chk("t1_last", last_hi[0], t_trig[5] + 111);
    chk("t1_width", hi_cnt[0], 100);

    // Window wrapping through tooth 0
    set_win(0, 57, 1, 0, 0);
    load_cfg();
    clear_trk();
    run_teeth(0, 59, 100);
    run_teeth(0, 1, 100);
    chk("t2_width", hi_cnt[0], 400);
    chk("t2_first", first_hi[0], t_trig[57] + 2);
    chk("t2_last", last_hi[0], t_trig[1] + 1);

    // Coincident start and end
    set_win(0, 3, 3, 20, 20);
    load_cfg();
    clear_trk();
    run_teeth(0, 59, 100);
    chk("t3_never", hi_cnt[0], 0);
    chk("t3_never_d", hi_cnt[1], 0);

    // Dwell limit
    set_win(0, 10, 11, 0, 0);
    fault_clr = 1'b1;
    load_cfg();
    fault_clr = 1'b0;
    chk("t4_clr_pre", fault1, 0);
    clear_trk();
    run_teeth(0, 59, 100);
    chk("t4_width_d", hi_cnt[1], 51);
    chk("t4_first_d", first_hi[1], t_trig[10] + 2);
    chk("t4_width", hi_cnt[0], 100);
    chk("t4_sticky_d", fault1[0], 1);
    chk("t4_nofault", fault0[0], 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("t4_cleared_d", fault1[0], 0);
    g_clr_tooth = 10; g_clr_at = 52;
    clear_trk();
    run_teeth(0, 59, 100);
    g_clr_tooth = -1; g_clr_at = -1;
    chk("t4_rearm_d", hi_cnt[1], 51);
    chk("t4_set_beats_clr", fault1[0], 1);

    // Shadow commit only at tooth 0
    set_win(0, 30, 31, 0, 0);
    load_cfg();
    run_teeth(0, 59, 100);
    set_win(0, 25, 31, 0, 0);
    g_load_tooth = 20; g_load_at = 5;
    clear_trk();
    run_teeth(0, 20, 100);
    g_load_tooth = -1; g_load_at = -1;
    chk("t5_pending_t20", cfg_pending0, 1);
    run_teeth(21, 59, 100);
    chk("t5_pending_t59", cfg_pending0, 1);
    chk("t5_old_width", hi_cnt[0], 100);
    chk("t5_old_first", first_hi[0], t_trig[30] + 2);
    clear_trk();
    run_teeth(0, 0, 100);
    chk("t5_committed", cfg_pending0, 0);
    run_teeth(1, 59, 100);
    chk("t5_new_width", hi_cnt[0], 600);
    chk("t5_new_first", first_hi[0], t_trig[25] + 2);

    // Distributor folding, then reset in the middle of a pulse
    ch_en = 4'b1111; distributor_mode = 1'b1;
    for (int c = 0; c < N; c++) set_win(c, 15*c, 15*c, 0, 50);
    load_cfg();
    clear_trk();
    run_teeth(0, 59, 100);
    chk("t6_folded", hi_cnt[0], 200);
    chk("t6_folded_d", hi_cnt[1], 200);
    chk("t6_upper_zero", others_hi, 0);
    g_load_tooth = 5; g_load_at = 3;
    run_teeth(0, 14, 100);
    g_load_tooth = -1; g_load_at = -1;
    run_teeth(15, 15, 20);
    chk("t6_mid_pulse", ch_out0[0], 1);
    chk("t6_pending_pre", cfg_pending0, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_reset_out", ch_out0, 0);
    chk("t6_reset_out_d", ch_out1, 0);
    chk("t6_reset_pending", cfg_pending0, 0);
    step();
    reset = 1'b0;
    step(); step();

    // Randomised revolutions
    g_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      g_len = $urandom_range(20, 50);
      ch_en = N'($urandom_range(0, 15));
      distributor_mode = 1'($urandom_range(0, 1));
      synced = 1'b1;
      randomize_req(g_len);
      load_cfg();
      run_teeth(0, 59, g_len);
    end
    g_rand = 1'b0; synced = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/efi_output_bank.md
Name: efi_output_bank

Overview:
Parametrised N-channel angle-scheduled output driver bank, generalising the fixed four ignition drivers. Each channel asserts its output between a start (tooth, count) and an end (tooth, count) position, measured from the synchroniser's tooth trigger. It adds the following over the fixed drivers:
- double-buffered configuration committed only at tooth 0
- per-channel maximum-on (dwell) protection with sticky fault flags
- distributor-mode folding of all channels onto channel 0

It sits between the sync block (eng_phase/trigger/synced) and the pins, with config supplied from the SPI register file.

Parameters:
N_CH, 4, number of output channels
TOOTH_W, 8, tooth index width
COUNT_W, 24, intra-tooth clk-cycle counter width
DWELL_W, 24, dwell guard counter width
MAX_DWELL, 40000, max consecutive clk cycles a channel may stay on

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
synced  in  1  sync block locked
trigger  in  1  one-clk pulse per tooth edge
eng_phase  in  TOOTH_W  current tooth index, valid with trigger
ch_en  in  N_CH  per-channel enable
distributor_mode  in  1  fold all channels onto ch_out[0]
cfg_in  in  N_CH*CFG_W  per-channel {start_tooth, end_tooth, start_count, end_count}; CFG_W = 2*TOOTH_W+2*COUNT_W; channel 0 in LSBs
cfg_load  in  1  one-clk pulse: capture cfg_in into shadow
fault_clr  in  1  clear all dwell_fault bits
cfg_pending  out  1  shadow captured, not yet committed
ch_out  out  N_CH  channel drive outputs
dwell_fault  out  N_CH  sticky dwell-limit fault per channel

Behaviour:
- Reset (async): all outputs 0.
  - active cfg and shadow cfg = 0; tooth_r = 0.
  - tcnt = all-ones, so no match occurs before the first trigger.
  - all channel states OFF; dwell counters 0.
- Tooth tracking:
  - on trigger: tooth_r <= eng_phase, tcnt <= 0.
  - otherwise tcnt <= tcnt+1, saturating at all-ones (no wrap through a missing-tooth gap).
- Events per channel c, evaluated on registered tooth_r/tcnt against the active cfg:
  - start_hit = (tooth_r==start_tooth) && (tcnt==start_count)
  - end_hit = (tooth_r==end_tooth) && (tcnt==end_count)
- Channel state (registered):
  - OFF -> ON on start_hit && !end_hit && gate.
  - ON -> OFF on end_hit, on dwell expiry, or on !gate.
  - start_hit and end_hit in the same cycle -> OFF (end wins).
  - gate = synced & ch_en[c]; loss of gate forces OFF on the next clk.
- Latency: output rises 2 clk after the trigger cycle when start_count=0 (trigger at T; tcnt=0 at T+1; ch_out high at T+2). Falls 1 clk after the end_hit cycle.
- Windows crossing the tooth wrap (start_tooth > end_tooth) need no special handling: events are independent.
- Dwell guard:
  - the counter increments each cycle while ON and clears when OFF.
  - when the counter reaches MAX_DWELL: force OFF next clk and set dwell_fault[c].
  - the channel stays OFF until its next start_hit.
  - dwell_fault is sticky until fault_clr; a fault setting in the same cycle as fault_clr leaves it set.
- Configuration:
  - cfg_load: shadow <= cfg_in, cfg_pending <= 1.
  - commit (active <= shadow, cfg_pending <= 0) occurs on:
    - a trigger with eng_phase==0, or
    - any cycle with pending && !synced.
  - cfg_load coincident with commit: the commit uses the old shadow, the new value is captured, and cfg_pending stays 1.
  - Channels already ON keep running and evaluate their end event against the newly committed config.
- Output mapping:
  - distributor_mode=0: ch_out[c] = state[c].
  - distributor_mode=1: ch_out[0] = OR of all states; ch_out[N_CH-1:1] = 0.
  - The OR is taken over flops only; no other combinational logic sits in the output path.
- Reset mid-pulse: asynchronous clear; ch_out drops in the same cycle reset asserts.

Test Plan:
1. Window within a tooth:
   - stimulus: synced=1, ch_en=4'b0001, cfg ch0 = {start 5, end 5, start_count 10, end_count 110}, commit at tooth 0, then trigger with eng_phase=5.
   - required: ch_out[0] high from T+12 to T+111 inclusive (100 clk); ch_out[0] not high in any cycle outside that span.
2. Wrap window:
   - stimulus: start 57/0, end 1/0, 60 teeth, 100 clk per tooth.
   - required: ch_out[0] high across teeth 57..59, 0, ending 1 clk after tooth-1 tcnt==0; ON duration exactly 400 clk.
3. Coincident events:
   - stimulus: start = end = {3, 3, 20, 20}.
   - required: ch_out[0] never asserts.
4. Dwell fault:
   - stimulus: MAX_DWELL=50, window 100 clk long.
   - required: ch_out[0] high exactly 51 clk; dwell_fault[0] set; stays set until fault_clr; the next window asserts normally.
5. Shadow commit:
   - stimulus: cfg_load at tooth 20 with a new start_tooth.
   - required: cfg_pending=1 until the trigger with eng_phase=0; no new-config event occurs before that; the old config remains in effect for teeth 21..59.
6. Distributor mode and reset:
   - stimulus: distributor_mode=1 with channels 0..3 windows on teeth 0, 15, 30, 45.
   - required: all four pulses appear on ch_out[0]; ch_out[3:1] = 0.
   - stimulus: reset asserted mid-pulse.
   - required: ch_out = 0 immediately; cfg_pending = 0.
